vga_sprite_compositor: RTL and testbench

VGA_SPRITE_COMPOSITOR -- requirements
Module: vga_sprite_compositor

---
 rtl/vga_sprite_compositor.sv | 221 ++++++++++++++++++++++
 tb/tb_vga_sprite_compositor.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_compositor.sv
// VGA raster generator with a per-frame shadowed sprite overlay.
// Counters and bg_addr form stage 0, sprite hit tests are registered at
// stage 1, and final colour plus syncs/blank are registered at stage 2.
// The result is that every video output lags the raster counters by two cycles.
// bg_bgr comes from an external memory with a one-cycle registered read of bg_addr.
module vga_sprite_compositor #(
  parameter int NUM_SPR = 4,
  parameter int SPR_W   = 32,
  parameter int SPR_H   = 32,
  parameter int H_ACT   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYN   = 96,
  parameter int H_BP    = 48,
  parameter int V_ACT   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYN   = 2,
  parameter int V_BP    = 33
) (
  input  logic                    iVGA_CLK,
  input  logic                    iRST_n,
  input  logic [NUM_SPR*10-1:0]   spr_x,
  input  logic [NUM_SPR*9-1:0]    spr_y,
  input  logic [NUM_SPR-1:0]      spr_en,
  input  logic [NUM_SPR*24-1:0]   spr_bgr,
  output logic [18:0]             bg_addr,
  input  logic [23:0]             bg_bgr,
  output logic                    oHS,
  output logic                    oVS,
  output logic                    oBLANK_n,
  output logic [7:0]              b_data,
  output logic [7:0]              g_data,
  output logic [7:0]              r_data,
  output logic                    frame_start,
  output logic [NUM_SPR-1:0]      collision
);

  localparam int H_TOT = H_ACT + H_FP + H_SYN + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYN + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACT);
  localparam logic [HW-1:0] H_LAST_C = HW'(H_TOT - 1);
  localparam logic [HW-1:0] HS_BEG_C = HW'(H_ACT + H_FP);
  localparam logic [HW-1:0] HS_END_C = HW'(H_ACT + H_FP + H_SYN);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACT);
  localparam logic [VW-1:0] V_LAST_C = VW'(V_TOT - 1);
  localparam logic [VW-1:0] VS_BEG_C = VW'(V_ACT + V_FP);
  localparam logic [VW-1:0] VS_END_C = VW'(V_ACT + V_FP + V_SYN);

  // stage 0: raster counters and background address
  logic [HW-1:0]  hcnt_q, hcnt_d;
  logic [VW-1:0]  vcnt_q, vcnt_d;
  logic [18:0]    bg_addr_q, bg_addr_d;
  logic           frame_start_q, frame_start_d;
  logic           active0, hs0, vs0, latch, active_next;

  // shadow copies of the sprite inputs, loaded once per frame
  logic [NUM_SPR*10-1:0] shx_q, shx_d;
  logic [NUM_SPR*9-1:0]  shy_q, shy_d;
  logic [NUM_SPR-1:0]    shen_q, shen_d;
  logic [NUM_SPR*24-1:0] shc_q, shc_d;

  // collision tracking
  logic [NUM_SPR-1:0] hit;
  logic               multi_hit;
  logic [NUM_SPR-1:0] acc_q, acc_d;
  logic [NUM_SPR-1:0] collision_q, collision_d;

  // stage 1: hit result
  logic        act1_q, act1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic        spr_hit1_q, spr_hit1_d;
  logic [23:0] spr_bgr1_q, spr_bgr1_d;

  // stage 2: final pixel
  logic        blank2_q, blank2_d, hs2_q, hs2_d, vs2_q, vs2_d;
  logic [23:0] bgr2_q, bgr2_d;

  logic [10:0] x11, y11;

  // raster counter advance: hcnt wraps each line, vcnt each frame
  always_comb begin
    hcnt_d = hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST_C) begin
      hcnt_d = '0;
      if (vcnt_q == V_LAST_C) vcnt_d = '0;
      else                    vcnt_d = vcnt_q + 1'b1;
    end
  end

  // decode of the current raster position and incremental background address
  always_comb begin
    active0       = (hcnt_q < H_ACT_C) && (vcnt_q < V_ACT_C);
    hs0           = !((hcnt_q >= HS_BEG_C) && (hcnt_q < HS_END_C));
    vs0           = !((vcnt_q >= VS_BEG_C) && (vcnt_q < VS_END_C));
    latch         = (hcnt_q == '0) && (vcnt_q == V_ACT_C);
    frame_start_d = (hcnt_d == '0) && (vcnt_d == V_ACT_C);
    active_next   = (hcnt_d < H_ACT_C) && (vcnt_d < V_ACT_C);
    // address tracks the pixel the counters point at; it holds through blanking
    if ((hcnt_d == '0) && (vcnt_d == '0)) bg_addr_d = '0;
    else if (active_next)                 bg_addr_d = bg_addr_q + 19'd1;
    else                                  bg_addr_d = bg_addr_q;
  end

  // shadow load at the start of vertical blanking so a frame never tears
  always_comb begin
    shx_d  = shx_q;
    shy_d  = shy_q;
    shen_d = shen_q;
    shc_d  = shc_q;
    if (latch) begin
      shx_d  = spr_x;
      shy_d  = spr_y;
      shen_d = spr_en;
      shc_d  = spr_bgr;
    end
  end

  assign x11 = 11'(hcnt_q);
  assign y11 = 11'(vcnt_q);

  // per-sprite rectangle test in 11 bits so right/bottom overhang clips instead of wrapping
  for (genvar gi = 0; gi < NUM_SPR; gi++) begin : g_hit
    logic [10:0] sx, sy;
    assign sx = {1'b0, shx_q[10*gi +: 10]};
    assign sy = {2'b00, shy_q[9*gi +: 9]};
    assign hit[gi] = active0 && shen_q[gi] &&
                     (x11 >= sx) && (x11 < sx + 11'(SPR_W)) &&
                     (y11 >= sy) && (y11 < sy + 11'(SPR_H));
  end

  // stage 1: lowest-index hitting sprite wins; collision accumulates multi-hits
  always_comb begin
    act1_d     = active0;
    hs1_d      = hs0;
    vs1_d      = vs0;
    spr_hit1_d = 1'b0;
    spr_bgr1_d = '0;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (hit[i]) begin
        spr_hit1_d = 1'b1;
        spr_bgr1_d = shc_q[24*i +: 24];
      end
    end
    // more than one bit set <=> clearing the lowest set bit leaves something
    multi_hit   = |(hit & (hit - 1'b1));
    acc_d       = acc_q | (multi_hit ? hit : '0);
    collision_d = collision_q;
    if (latch) begin
      collision_d = acc_q;
      acc_d       = '0;
    end
  end

  // stage 2: merge sprite colour over background, black outside active video
  always_comb begin
    blank2_d = act1_q;
    hs2_d    = hs1_q;
    vs2_d    = vs1_q;
    if (!act1_q)         bgr2_d = '0;
    else if (spr_hit1_q) bgr2_d = spr_bgr1_q;
    else                 bgr2_d = bg_bgr;
  end

  // all state, cleared asynchronously so a mid-line reset blanks the output at once
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      bg_addr_q     <= '0;
      frame_start_q <= 1'b0;
      shx_q         <= '0;
      shy_q         <= '0;
      shen_q        <= '0;
      shc_q         <= '0;
      acc_q         <= '0;
      collision_q   <= '0;
      act1_q        <= 1'b0;
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
      spr_hit1_q    <= 1'b0;
      spr_bgr1_q    <= '0;
      blank2_q      <= 1'b0;
      hs2_q         <= 1'b1;
      vs2_q         <= 1'b1;
      bgr2_q        <= '0;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      bg_addr_q     <= bg_addr_d;
      frame_start_q <= frame_start_d;
      shx_q         <= shx_d;
      shy_q         <= shy_d;
      shen_q        <= shen_d;
      shc_q         <= shc_d;
      acc_q         <= acc_d;
      collision_q   <= collision_d;
      act1_q        <= act1_d;
      hs1_q         <= hs1_d;
      vs1_q         <= vs1_d;
      spr_hit1_q    <= spr_hit1_d;
      spr_bgr1_q    <= spr_bgr1_d;
      blank2_q      <= blank2_d;
      hs2_q         <= hs2_d;
      vs2_q         <= vs2_d;
      bgr2_q        <= bgr2_d;
    end
  end

  assign bg_addr     = bg_addr_q;
  assign frame_start = frame_start_q;
  assign collision   = collision_q;
  assign oHS         = hs2_q;
  assign oVS         = vs2_q;
  assign oBLANK_n    = blank2_q;
  assign b_data      = bgr2_q[23:16];
  assign g_data      = bgr2_q[15:8];
  assign r_data      = bgr2_q[7:0];

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Scoreboard bench for vga_sprite_compositor on a reduced raster
// (80x55 total, 64x48 active, 8x6 sprites).
module tb_vga_sprite_compositor;

  localparam int N  = 4;
  localparam int SW = 8;
  localparam int SH = 6;
  localparam int HA = 64, HF = 4, HSY = 8, HB = 4;
  localparam int VA = 48, VF = 2, VSY = 2, VB = 3;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        blank;
    logic [23:0] bgr;
  } pix_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N*10-1:0] spr_x = '0;
  logic [N*9-1:0]  spr_y = '0;
  logic [N-1:0]    spr_en = '0;
  logic [N*24-1:0] spr_bgr = '0;
  logic [18:0]     bg_addr;
  logic [23:0]     bg_bgr;
  logic            ohs, ovs, oblank_n, frame_start;
  logic [7:0]      b_data, g_data, r_data;
  logic [N-1:0]    collision;

  int errors = 0;
  int checks = 0;

  // reference state: cycle count since reset and the shadow config the model believes is live
  int           cyc;
  int           m_x [N];
  int           m_y [N];
  bit           m_en [N];
  logic [23:0]  m_c [N];
  logic [N-1:0] exp_coll;
  pix_t         exp_q [$];
  pix_t         e_mon;

  always #5 clk = ~clk;

  vga_sprite_compositor #(
    .NUM_SPR(N), .SPR_W(SW), .SPR_H(SH),
    .H_ACT(HA), .H_FP(HF), .H_SYN(HSY), .H_BP(HB),
    .V_ACT(VA), .V_FP(VF), .V_SYN(VSY), .V_BP(VB)
  ) dut (
    .iVGA_CLK(clk), .iRST_n(rst_n),
    .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en), .spr_bgr(spr_bgr),
    .bg_addr(bg_addr), .bg_bgr(bg_bgr),
    .oHS(ohs), .oVS(ovs), .oBLANK_n(oblank_n),
    .b_data(b_data), .g_data(g_data), .r_data(r_data),
    .frame_start(frame_start), .collision(collision)
  );

  function automatic logic [23:0] bg_fn(input logic [18:0] a);
    return {a[7:0] ^ 8'h3C, a[15:8] ^ {5'b0, a[18:16]}, ~a[7:0]};
  endfunction

  // background memory with one-cycle registered read
  always @(posedge clk) bg_bgr <= bg_fn(bg_addr);

  function automatic int cur_x();
    return (cyc % FRAME) % HT;
  endfunction

  function automatic int cur_y();
    return (cyc % FRAME) / HT;
  endfunction

  function automatic pix_t model_pix(input int x, input int y);
    pix_t p;
    p.hs    = !(x >= HA + HF && x < HA + HF + HSY);
    p.vs    = !(y >= VA + VF && y < VA + VF + VSY);
    p.blank = (x < HA) && (y < VA);
    p.bgr   = '0;
    if (p.blank) begin
      p.bgr = bg_fn(19'(y * HA + x));
      for (int i = N - 1; i >= 0; i--)
        if (m_en[i] && x >= m_x[i] && x < m_x[i] + SW && y >= m_y[i] && y < m_y[i] + SH)
          p.bgr = m_c[i];
    end
    return p;
  endfunction

  function automatic bit span_ovl(input int a, input int b, input int w, input int lim);
    int lo, hi;
    lo = (a > b) ? a : b;
    hi = (a < b) ? a + w : b + w;
    if (hi > lim) hi = lim;
    return lo < hi;
  endfunction

  // pairwise rectangle intersection inside the visible area
  function automatic logic [N-1:0] model_coll();
    logic [N-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++)
      for (int j = i + 1; j < N; j++)
        if (m_en[i] && m_en[j] && span_ovl(m_x[i], m_x[j], SW, HA) && span_ovl(m_y[i], m_y[j], SH, VA)) begin
          c[i] = 1'b1;
          c[j] = 1'b1;
        end
    return c;
  endfunction

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
      if (errors >= 40) finish_run();
    end
  endtask

  // reference model: each cycle queue the expected pixel for the current raster slot
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc      <= 0;
      exp_coll <= '0;
      exp_q.delete();
      for (int i = 0; i < N; i++) begin
        m_x[i]  <= 0;
        m_y[i]  <= 0;
        m_en[i] <= 1'b0;
        m_c[i]  <= '0;
      end
    end else begin
      exp_q.push_back(model_pix(cur_x(), cur_y()));
      if (cur_x() == 0 && cur_y() == VA) begin
        exp_coll <= model_coll();
        for (int i = 0; i < N; i++) begin
          m_x[i]  <= int'(spr_x[10*i +: 10]);
          m_y[i]  <= int'(spr_y[9*i +: 9]);
          m_en[i] <= spr_en[i];
          m_c[i]  <= spr_bgr[24*i +: 24];
        end
      end
      cyc <= cyc + 1;
    end
  end

  // monitor: pop the oldest expected pixel once the two-stage pipeline has filled
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 1) begin
        e_mon = exp_q.pop_front();
        chk("pixel{hs,vs,blank,bgr}", {5'b0, ohs, ovs, oblank_n, b_data, g_data, r_data}, {5'b0, e_mon});
      end
      chk("frame_start", {31'b0, frame_start}, {31'b0, (cur_x() == 0 && cur_y() == VA)});
      chk("collision", {28'b0, collision}, {28'b0, exp_coll});
      if (cur_x() < HA && cur_y() < VA)
        chk("bg_addr", {13'b0, bg_addr}, 32'(cur_y() * HA + cur_x()));
      if (frame_start)
        $display("latch t=%0t collision=%b", $time, collision);
    end
  end

  task automatic wait_px(input int x, input int y);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(cur_x() == x && cur_y() == y) && n < FRAME + HT);
    chk("wait_px_reached", {31'b0, (cur_x() == x && cur_y() == y)}, 32'd1);
  endtask

  task automatic set_spr(input int i, input int x, input int y, input bit en, input logic [23:0] c);
    spr_x[10*i +: 10] = 10'(x);
    spr_y[9*i +: 9]   = 9'(y);
    spr_en[i]         = en;
    spr_bgr[24*i +: 24] = c;
  endtask

  task automatic apply_cfg(input int f);
    int x, y;
    spr_en = '0;
    case (f)
      0: set_spr(0, 20, 10, 1'b1, 24'hFF0000);
      1: begin
        set_spr(0, 10, 10, 1'b1, 24'h0000FF);
        set_spr(1, 14, 13, 1'b1, 24'h00FF00);
      end
      2: begin
        set_spr(0, 10, 10, 1'b1, 24'h0000FF);
        set_spr(1, 30, 30, 1'b1, 24'h00FF00);
      end
      3: begin
        set_spr(0, HA - 4, VA - 3, 1'b1, 24'h123456);
        set_spr(1, 1020, 500, 1'b1, 24'hABCDEF);
        set_spr(2, HA + 2, 20, 1'b1, 24'h777777);
        set_spr(3, HA + 2, 20, 1'b1, 24'h888888);
      end
      4: begin
        set_spr(0, 5, 5, 1'b1, 24'h00AA00);
        set_spr(1, 5, 5, 1'b0, 24'hAA0000);
        set_spr(3, 40, 20, 1'b1, 24'h0000AA);
      end
      default: begin
        for (int i = 0; i < N; i++) begin
          x = ($urandom_range(7, 0) == 0) ? int'($urandom_range(1023, 1000)) : int'($urandom_range(HA + SW, 0));
          y = ($urandom_range(7, 0) == 0) ? int'($urandom_range(511, 490)) : int'($urandom_range(VA + SH, 0));
          set_spr(i, x, y, 1'($urandom_range(1, 0)), 24'($urandom));
        end
      end
    endcase
  endtask

  initial begin
    int row;
    repeat (3) @(negedge clk);
    chk("rst_hs", {31'b0, ohs}, 32'd1);
    chk("rst_vs", {31'b0, ovs}, 32'd1);
    chk("rst_blank", {31'b0, oblank_n}, 32'd0);
    chk("rst_rgb", {8'b0, b_data, g_data, r_data}, 32'd0);
    chk("rst_bg_addr", {13'b0, bg_addr}, 32'd0);
    chk("rst_frame_start", {31'b0, frame_start}, 32'd0);
    chk("rst_collision", {28'b0, collision}, 32'd0);
    rst_n = 1'b1;

    for (int f = 0; f < 10; f++) begin
      if (f == 6) begin
        wait_px(30, 10);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_hs", {31'b0, ohs}, 32'd1);
        chk("midrst_vs", {31'b0, ovs}, 32'd1);
        chk("midrst_blank", {31'b0, oblank_n}, 32'd0);
        chk("midrst_rgb", {8'b0, b_data, g_data, r_data}, 32'd0);
        chk("midrst_bg_addr", {13'b0, bg_addr}, 32'd0);
        chk("midrst_frame_start", {31'b0, frame_start}, 32'd0);
        chk("midrst_collision", {28'b0, collision}, 32'd0);
        $display("reset asserted mid-line t=%0t", $time);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
      end
      row = int'($urandom_range(VA - 2, 1));
      wait_px(5, row);
      apply_cfg(f);
      $display("config %0d applied at row %0d: en=%b x=%h y=%h", f, row, spr_en, spr_x, spr_y);
      wait_px(0, VA + 1);
    end
    // let the last configuration display and report its collisions
    wait_px(0, VA + 1);
    finish_run();
  end

  initial begin
    #1500000;
    checks++;
    errors++;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    finish_run();
  end

endmodule
